ctrl_multiciclo: RTL and testbench
==================================

Name: ctrl_multiciclo

Overview:
Multicycle control FSM for the RV32I-subset datapath. Produces the 4-bit `estado` bus shared by all datapath modules, including the PC unit, which advances PC only while `estado` = 4'b0111. Decodes opcode and funct3, sequences fetch/decode/execute/memory/writeback, and drives `pcsrc` and the per-state control strobes. Supported instructions: lw, sw, R-type ALU, addi-class I-type, beq/bne.

Parameters:
MEM_LAT, 1, cycles spent in each of MEMREAD and MEMWRITE; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  7  instruction bits [6:0] from the instruction register
funct3  input  3  instruction bits [14:12]
zero  input  1  ALU zero flag, valid in BRANCH
estado  output  4  current FSM state, registered
pcsrc  output  1  0: PC+1; 1: PC+imm/4; valid in PCUPDATE
ir_load  output  1  load instruction register
regwrite  output  1  register file write enable
memread  output  1  data memory read strobe
memwrite  output  1  data memory write strobe
alusrc  output  1  0: rs2; 1: immediate
aluop  output  2  00 add, 01 sub/compare, 10 funct-decoded
memtoreg  output  1  writeback source; 1: memory, 0: ALU
instr_done  output  1  one-cycle pulse in PCUPDATE
illegal  output  1  sticky; high in TRAP
perf_cycles  output  32  cycle counter (optional feature)
perf_instrs  output  32  retired-instruction counter (optional feature)

Behaviour:
- Reset (sync, priority over everything): `estado` = FETCH, memory-wait counter = 0, branch latch = 0, all counters = 0. All strobes are decoded from `estado`, so after reset they are: `ir_load`=1, every other strobe 0, `illegal`=0.
- Outputs are a pure decode of registered `estado`; no output depends combinationally on `opcode`, `funct3` or `zero`.
- State encodings, active strobes, and next state:
  - 0000 FETCH: `ir_load`. Next: DECODE.
  - 0001 DECODE: no strobes. Next state by opcode:
    - 0000011 or 0100011 → MEMADDR
    - 0110011 → REXEC
    - 0010011 → IEXEC
    - 1100011 → BRANCH
    - anything else → TRAP
  - 0010 MEMADDR: `alusrc`=1, `aluop`=00. Next: MEMREAD if opcode = lw, MEMWRITE if opcode = sw.
  - 0011 MEMREAD: `memread`. Stay MEM_LAT cycles, then MEMWB.
  - 0100 MEMWRITE: `memwrite`. Stay MEM_LAT cycles, then PCUPDATE.
  - 1001 MEMWB: `regwrite`, `memtoreg`=1. Next: PCUPDATE.
  - 0101 REXEC: `aluop`=10, `alusrc`=0. Next: ALUWB.
  - 0110 IEXEC: `aluop`=00, `alusrc`=1. Next: ALUWB.
  - 1010 ALUWB: `regwrite`, `memtoreg`=0. Next: PCUPDATE.
  - 1000 BRANCH: `aluop`=01. Latch `taken` = (funct3 = 000 & zero) | (funct3 = 001 & ~zero). Any other funct3 → `taken`=0. Next: PCUPDATE.
  - 0111 PCUPDATE: `pcsrc` = `taken`, `instr_done`=1. Clear `taken`. Next: FETCH.
  - 1111 TRAP: `illegal`=1, all strobes 0. Held until reset.
  - Unused encodings (1011–1110): go to TRAP on the next cycle.
- Memory-wait counter: 4 bits. Loads 0 on entry to MEMREAD/MEMWRITE. Exits when count = MEM_LAT−1; MEM_LAT=1 gives a single cycle.
- The `taken` latch is written only in BRANCH. Non-branch instructions always leave PCUPDATE with `pcsrc`=0.
- Latency (MEM_LAT=1):
  - R/I-type: 5 cycles
  - sw: 5 cycles
  - lw: 6 cycles
  - branch: 4 cycles
- At most one strobe among `regwrite`/`memread`/`memwrite` is high in any cycle.
- Reset asserted mid-instruction: next state is FETCH, no strobes leak, `pcsrc`=0.

Optional Feature:
CTRL_PERF_EN
- Defined:
  - `perf_cycles` increments every non-reset cycle, wrapping at 2^32.
  - `perf_instrs` increments on each `instr_done`, wrapping.
  - Both freeze in TRAP and clear on reset.
- Undefined: both ports tie to 32'd0 and no counter logic is synthesized.

Test Plan:
- reset held 3 cycles, then released, opcode=0110011 → `estado` sequence 0000,0001,0101,1010,0111,0000; `regwrite` high only in 1010; `pcsrc`=0 in 0111.
- lw (opcode 0000011), MEM_LAT=3 → 0000,0001,0010,0011×3,1001,0111; `memread` high for exactly 3 cycles; `memtoreg`=1 in 1001.
- beq: funct3=000, zero=1 → `pcsrc`=1 in 0111. Same with zero=0 → `pcsrc`=0. bne (001) with zero=0 → `pcsrc`=1.
- opcode 1111111 → DECODE then 1111; `illegal`=1 and all strobes 0 for 20 cycles; reset returns to 0000 with `illegal`=0.
- reset asserted while in MEMWRITE with MEM_LAT=4 → next `estado`=0000, `memwrite`=0; the following sw completes normally.
- CTRL_PERF_EN defined, 10 back-to-back addi instructions → `perf_instrs`=10, `perf_cycles`=50 at the 10th `instr_done` edge.

Source files
------------

// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM for the RV32I-subset datapath.
// Optional perf counters enabled by defining CTRL_PERF_EN.
package ctrl_multiciclo_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'b0000,
    S_DECODE   = 4'b0001,
    S_MEMADDR  = 4'b0010,
    S_MEMREAD  = 4'b0011,
    S_MEMWRITE = 4'b0100,
    S_REXEC    = 4'b0101,
    S_IEXEC    = 4'b0110,
    S_PCUPDATE = 4'b0111,
    S_BRANCH   = 4'b1000,
    S_MEMWB    = 4'b1001,
    S_ALUWB    = 4'b1010,
    S_TRAP     = 4'b1111
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

endpackage

module ctrl_multiciclo
  import ctrl_multiciclo_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  output logic [3:0]  estado,
  output logic        pcsrc,
  output logic        ir_load,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic        memtoreg,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instrs
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] mcnt_q;
  logic       taken_q;
  logic       last_mem;
  logic       br_taken;
  logic       in_mem;

  logic is_lw, is_sw, is_r, is_i, is_br;

  assign is_lw = (opcode == OP_LW);
  assign is_sw = (opcode == OP_SW);
  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_br = (opcode == OP_BR);

  assign last_mem = (mcnt_q == 4'(MEM_LAT - 1));
  assign in_mem   = (state_q == S_MEMREAD)
                 || (state_q == S_MEMWRITE);

  assign br_taken = ((funct3 == 3'b000) && zero)
                 || ((funct3 == 3'b001) && !zero);

  assign estado = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      mcnt_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_mem && !last_mem) begin
        mcnt_q <= mcnt_q + 4'd1;
      end else begin
        mcnt_q <= '0;
      end
      if (state_q == S_BRANCH) begin
        taken_q <= br_taken;
      end else if (state_q == S_PCUPDATE) begin
        taken_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = S_TRAP;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADDR;
          is_r:         state_d = S_REXEC;
          is_i:         state_d = S_IEXEC;
          is_br:        state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADDR: begin
        unique case (1'b1)
          is_lw:   state_d = S_MEMREAD;
          is_sw:   state_d = S_MEMWRITE;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMREAD:
        state_d = last_mem ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:
        state_d = last_mem ? S_PCUPDATE : S_MEMWRITE;
      S_MEMWB:    state_d = S_PCUPDATE;
      S_REXEC:    state_d = S_ALUWB;
      S_IEXEC:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_PCUPDATE;
      S_BRANCH:   state_d = S_PCUPDATE;
      S_PCUPDATE: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Strobes depend only on the registered state.
  always_comb begin
    pcsrc      = 1'b0;
    ir_load    = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrc     = 1'b0;
    aluop      = 2'b00;
    memtoreg   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH:    ir_load = 1'b1;
      S_MEMADDR:  alusrc  = 1'b1;
      S_MEMREAD:  memread = 1'b1;
      S_MEMWRITE: memwrite = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_REXEC:    aluop    = 2'b10;
      S_IEXEC:    alusrc   = 1'b1;
      S_ALUWB:    regwrite = 1'b1;
      S_BRANCH:   aluop    = 2'b01;
      S_PCUPDATE: begin
        pcsrc      = taken_q;
        instr_done = 1'b1;
      end
      S_TRAP:     illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] ins_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else if (state_q != S_TRAP) begin
      cyc_q <= cyc_q + 32'd1;
      if (instr_done) begin
        ins_q <= ins_q + 32'd1;
      end
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_instrs = ins_q;
`else
  assign perf_cycles = 32'd0;
  assign perf_instrs = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Bench for ctrl_multiciclo: three instances (MEM_LAT 1/3/4)
// checked against a per-cycle expected-output queue.
module tb_ctrl_multiciclo;

  localparam logic [3:0] ST_FETCH = 4'b0000;
  localparam logic [3:0] ST_DEC   = 4'b0001;
  localparam logic [3:0] ST_MADDR = 4'b0010;
  localparam logic [3:0] ST_MRD   = 4'b0011;
  localparam logic [3:0] ST_MWR   = 4'b0100;
  localparam logic [3:0] ST_REX   = 4'b0101;
  localparam logic [3:0] ST_IEX   = 4'b0110;
  localparam logic [3:0] ST_PCU   = 4'b0111;
  localparam logic [3:0] ST_BR    = 4'b1000;
  localparam logic [3:0] ST_MWB   = 4'b1001;
  localparam logic [3:0] ST_AWB   = 4'b1010;
  localparam logic [3:0] ST_TRAP  = 4'b1111;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] estado;
    logic       ir_load;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic [1:0] aluop;
    logic       memtoreg;
    logic       pcsrc;
    logic       instr_done;
    logic       illegal;
  } exp_t;

  typedef struct {
    int         k;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         cyc;
    logic       pc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;

  logic [3:0]  est [3];
  logic        pcs [3];
  logic        irl [3];
  logic        rw  [3];
  logic        mr  [3];
  logic        mw  [3];
  logic        asr [3];
  logic [1:0]  aop [3];
  logic        m2r [3];
  logic        idn [3];
  logic        ill [3];
  logic [31:0] pfc [3];
  logic [31:0] pfi [3];

  int lats [3] = '{1, 3, 4};
  int checks = 0;
  int errors = 0;
  exp_t sbq [$];

  always #5 clk = ~clk;

  ctrl_multiciclo #(.MEM_LAT(1)) d0 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .funct3(funct3), .zero(zero), .estado(est[0]),
    .pcsrc(pcs[0]), .ir_load(irl[0]),
    .regwrite(rw[0]), .memread(mr[0]),
    .memwrite(mw[0]), .alusrc(asr[0]),
    .aluop(aop[0]), .memtoreg(m2r[0]),
    .instr_done(idn[0]), .illegal(ill[0]),
    .perf_cycles(pfc[0]), .perf_instrs(pfi[0])
  );

  ctrl_multiciclo #(.MEM_LAT(3)) d1 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .funct3(funct3), .zero(zero), .estado(est[1]),
    .pcsrc(pcs[1]), .ir_load(irl[1]),
    .regwrite(rw[1]), .memread(mr[1]),
    .memwrite(mw[1]), .alusrc(asr[1]),
    .aluop(aop[1]), .memtoreg(m2r[1]),
    .instr_done(idn[1]), .illegal(ill[1]),
    .perf_cycles(pfc[1]), .perf_instrs(pfi[1])
  );

  ctrl_multiciclo #(.MEM_LAT(4)) d2 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .funct3(funct3), .zero(zero), .estado(est[2]),
    .pcsrc(pcs[2]), .ir_load(irl[2]),
    .regwrite(rw[2]), .memread(mr[2]),
    .memwrite(mw[2]), .alusrc(asr[2]),
    .aluop(aop[2]), .memtoreg(m2r[2]),
    .instr_done(idn[2]), .illegal(ill[2]),
    .perf_cycles(pfc[2]), .perf_instrs(pfi[2])
  );

  function automatic exp_t dec(input logic [3:0] s,
                               input logic tk);
    exp_t e;
    e = '0;
    e.estado = s;
    case (s)
      ST_FETCH: e.ir_load = 1'b1;
      ST_MADDR: e.alusrc = 1'b1;
      ST_MRD:   e.memread = 1'b1;
      ST_MWR:   e.memwrite = 1'b1;
      ST_MWB: begin
        e.regwrite = 1'b1;
        e.memtoreg = 1'b1;
      end
      ST_REX:   e.aluop = 2'b10;
      ST_IEX:   e.alusrc = 1'b1;
      ST_AWB:   e.regwrite = 1'b1;
      ST_BR:    e.aluop = 2'b01;
      ST_PCU: begin
        e.pcsrc = tk;
        e.instr_done = 1'b1;
      end
      ST_TRAP:  e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t act(input int k);
    return exp_t'({est[k], irl[k], rw[k], mr[k],
                   mw[k], asr[k], aop[k], m2r[k],
                   pcs[k], idn[k], ill[k]});
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset d%0d", k),
          32'(act(k)), 32'(dec(ST_FETCH, 1'b0)));
    reset = 1'b0;
  endtask

  task automatic run_instr(input int k,
                           input logic [6:0] op,
                           input logic [2:0] f3,
                           input logic z,
                           input int stop,
                           output int ncyc,
                           output logic pc);
    logic tk;
    exp_t e;
    exp_t a;
    int n;
    int lat;
    lat = lats[k];
    opcode = op;
    funct3 = f3;
    zero = z;
    tk = (op == BR) &&
         (((f3 == 3'b000) && z) ||
          ((f3 == 3'b001) && !z));
    sbq.push_back(dec(ST_FETCH, 1'b0));
    sbq.push_back(dec(ST_DEC, 1'b0));
    case (op)
      LW: begin
        sbq.push_back(dec(ST_MADDR, 1'b0));
        repeat (lat) sbq.push_back(dec(ST_MRD, 1'b0));
        sbq.push_back(dec(ST_MWB, 1'b0));
        sbq.push_back(dec(ST_PCU, 1'b0));
      end
      SW: begin
        sbq.push_back(dec(ST_MADDR, 1'b0));
        repeat (lat) sbq.push_back(dec(ST_MWR, 1'b0));
        sbq.push_back(dec(ST_PCU, 1'b0));
      end
      RT, IT: begin
        sbq.push_back(dec(op == RT ? ST_REX : ST_IEX,
                          1'b0));
        sbq.push_back(dec(ST_AWB, 1'b0));
        sbq.push_back(dec(ST_PCU, 1'b0));
      end
      BR: begin
        sbq.push_back(dec(ST_BR, 1'b0));
        sbq.push_back(dec(ST_PCU, tk));
      end
      default:
        repeat (20) sbq.push_back(dec(ST_TRAP, 1'b0));
    endcase
    ncyc = 0;
    pc = 1'b0;
    n = 0;
    while (sbq.size() > 0 && (stop < 0 || n < stop)) begin
      e = sbq.pop_front();
      a = act(k);
      chk($sformatf("d%0d op%0h cyc%0d", k, op, n),
          32'(a), 32'(e));
      if (ncyc == 0 && a.instr_done) begin
        ncyc = n + 1;
        pc = a.pcsrc;
      end
      n++;
      if (sbq.size() > 0 && (stop < 0 || n < stop))
        step();
    end
    sbq.delete();
    if (stop < 0) step();
  endtask

  vec_t vt [15];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int nc;
    logic pc;
    int pk;
    reset = 1'b1;
    opcode = RT;
    funct3 = 3'b000;
    zero = 1'b0;

    vt[0]  = '{0, RT, 3'b000, 1'b0, 5, 1'b0};
    vt[1]  = '{0, IT, 3'b000, 1'b0, 5, 1'b0};
    vt[2]  = '{0, LW, 3'b010, 1'b0, 6, 1'b0};
    vt[3]  = '{0, SW, 3'b010, 1'b0, 5, 1'b0};
    vt[4]  = '{0, BR, 3'b000, 1'b1, 4, 1'b1};
    vt[5]  = '{0, RT, 3'b000, 1'b1, 5, 1'b0};
    vt[6]  = '{0, BR, 3'b000, 1'b0, 4, 1'b0};
    vt[7]  = '{0, BR, 3'b001, 1'b0, 4, 1'b1};
    vt[8]  = '{0, BR, 3'b001, 1'b1, 4, 1'b0};
    vt[9]  = '{0, BR, 3'b100, 1'b1, 4, 1'b0};
    vt[10] = '{0, IT, 3'b000, 1'b1, 5, 1'b0};
    vt[11] = '{1, LW, 3'b010, 1'b0, 8, 1'b0};
    vt[12] = '{1, SW, 3'b010, 1'b0, 7, 1'b0};
    vt[13] = '{2, SW, 3'b010, 1'b0, 8, 1'b0};
    vt[14] = '{2, LW, 3'b010, 1'b0, 9, 1'b0};

    do_reset(3);

    pk = 0;
    foreach (vt[i]) begin
      if (vt[i].k != pk) do_reset(1);
      pk = vt[i].k;
      run_instr(vt[i].k, vt[i].op, vt[i].f3,
                vt[i].z, -1, nc, pc);
      chk($sformatf("latency v%0d", i),
          32'(nc), 32'(vt[i].cyc));
      chk($sformatf("pcsrc v%0d", i),
          32'(pc), 32'(vt[i].pc));
    end

    // Reset in the second MEMWRITE cycle (MEM_LAT=4).
    do_reset(1);
    run_instr(2, SW, 3'b010, 1'b0, 5, nc, pc);
    reset = 1'b1;
    step();
    chk("midwrite reset", 32'(act(2)),
        32'(dec(ST_FETCH, 1'b0)));
    reset = 1'b0;
    run_instr(2, SW, 3'b010, 1'b0, -1, nc, pc);
    chk("sw after reset", 32'(nc), 32'd8);

    // Reset on the BRANCH edge must drop the taken latch.
    do_reset(1);
    run_instr(0, BR, 3'b000, 1'b1, 3, nc, pc);
    reset = 1'b1;
    step();
    chk("midbranch reset", 32'(act(0)),
        32'(dec(ST_FETCH, 1'b0)));
    reset = 1'b0;
    run_instr(0, RT, 3'b000, 1'b1, -1, nc, pc);
    chk("pcsrc after reset", 32'(pc), 32'd0);
    chk("rtype after reset", 32'(nc), 32'd5);

    // Illegal opcode sticks in TRAP until reset.
    run_instr(0, BAD, 3'b000, 1'b0, -1, nc, pc);
    chk("trap no done", 32'(nc), 32'd0);
    do_reset(1);
    chk("illegal cleared", 32'(ill[0]), 32'd0);

`ifdef CTRL_PERF_EN
    do_reset(1);
    repeat (10) run_instr(0, IT, 3'b000, 1'b0,
                          -1, nc, pc);
    chk("perf_instrs", pfi[0], 32'd10);
    chk("perf_cycles", pfc[0], 32'd50);
    run_instr(0, BAD, 3'b000, 1'b0, -1, nc, pc);
    chk("perf_cycles trap", pfc[0], 32'd52);
    chk("perf_instrs trap", pfi[0], 32'd10);
    do_reset(1);
    chk("perf_cycles clr", pfc[0], 32'd0);
`else
    repeat (3) run_instr(0, IT, 3'b000, 1'b0,
                         -1, nc, pc);
    chk("perf_cycles off", pfc[0], 32'd0);
    chk("perf_instrs off", pfi[0], 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
